// File: rtl/scan_code_event_fifo_if.sv
// ----------------------------------------------------------------------------
// scan_code_event_fifo_if: byte input, event output and status bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface scan_code_event_fifo_if #(
  parameter int AW = 3
);
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic        evt_ready;
  logic        clr_ovf;
  logic        evt_valid;
  logic [7:0]  evt_code;
  logic        evt_break;
  logic        evt_ext;
  logic [AW:0] level;
  logic        overflow;
  logic        seq_err;

  modport master (
    output scan_code, scan_valid, evt_ready, clr_ovf,
    input  evt_valid, evt_code, evt_break, evt_ext, level, overflow, seq_err
  );

  modport slave (
    input  scan_code, scan_valid, evt_ready, clr_ovf,
    output evt_valid, evt_code, evt_break, evt_ext, level, overflow, seq_err
  );
endinterface

`default_nettype wire

// File: rtl/scan_code_event_fifo.sv
// ----------------------------------------------------------------------------
// scan_code_event_fifo: E0/F0 prefix decoder feeding a show-ahead event FIFO
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scan_code_event_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  scan_code_event_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } state_t;

  localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic          seq_err_q, seq_err_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [9:0]    mem_q [DEPTH];

  logic       push;
  logic [9:0] evt_word;
  logic       full, empty, pop, wr_en, drop;
  logic [9:0] head;

  // Prefix decoder: only bytes that complete a key code produce an event.
  always_comb begin
    state_d   = state_q;
    seq_err_d = 1'b0;
    push      = 1'b0;
    evt_word  = {(state_q == ST_EXT) || (state_q == ST_EXTBRK),
                 (state_q == ST_BRK) || (state_q == ST_EXTBRK),
                 bus.scan_code};
    if (bus.scan_valid) begin
      case (bus.scan_code)
        8'hE0: begin
          seq_err_d = (state_q != ST_IDLE);
          state_d   = ST_EXT;
        end
        8'hF0: begin
          case (state_q)
            ST_IDLE: state_d = ST_BRK;
            ST_EXT:  state_d = ST_EXTBRK;
            default: begin
              seq_err_d = 1'b1;
              state_d   = ST_IDLE;
            end
          endcase
        end
        8'h00, 8'hFF: begin
          seq_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
        default: begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Occupancy comes from the level counter so a full FIFO never looks empty.
  always_comb begin
    full       = (level_q == c_full_level);
    empty      = (level_q == '0);
    pop        = !empty && bus.evt_ready;
    wr_en      = push && (!full || pop);
    drop       = push && full && !pop;
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - (AW+1)'(1);
    end
    overflow_d = drop ? 1'b1 : (bus.clr_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      seq_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      seq_err_q  <= seq_err_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-zero level.
  always_ff @(posedge fclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= evt_word;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.evt_valid = !empty;
  assign bus.evt_code  = empty ? 8'h00 : head[7:0];
  assign bus.evt_break = empty ? 1'b0 : head[8];
  assign bus.evt_ext   = empty ? 1'b0 : head[9];
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.seq_err   = seq_err_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_code_event_fifo.sv
// ----------------------------------------------------------------------------
// tb_scan_code_event_fifo: scoreboard bench with a queue-based reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_scan_code_event_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic fclk = 1'b0;
  logic rst_n;
  always #5 fclk = ~fclk;

  scan_code_event_fifo_if #(.AW(AW)) bus ();

  scan_code_event_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .fclk  (fclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];
  bit  m_ext, m_brk, m_ovf, m_serr;
  bit  pop, push, drop, nserr;
  ev_t ev;
  logic [7:0] b;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor + reference model: compare the present outputs, then advance the
  // model with the inputs that the next rising edge will consume.
  always @(negedge fclk) begin
    #2;
    if (!rst_n) begin
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_serr = 0;
    end else begin
      chk("evt_valid", bus.evt_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("evt_code",  bus.evt_code,  exp_q[0].code);
        chk("evt_break", bus.evt_break, exp_q[0].brk);
        chk("evt_ext",   bus.evt_ext,   exp_q[0].ext);
      end else begin
        chk("idle_fields", {bus.evt_ext, bus.evt_break, bus.evt_code}, 0);
      end
      chk("level",    bus.level,    exp_q.size());
      chk("overflow", bus.overflow, m_ovf);
      chk("seq_err",  bus.seq_err,  m_serr);

      pop   = (exp_q.size() > 0) && bus.evt_ready;
      push  = 0;
      nserr = 0;
      ev    = '0;
      if (bus.scan_valid) begin
        b = bus.scan_code;
        if (b == 8'hE0) begin
          nserr = m_ext || m_brk;
          m_ext = 1; m_brk = 0;
        end else if (b == 8'hF0) begin
          if (m_brk) begin
            nserr = 1; m_ext = 0; m_brk = 0;
          end else begin
            m_brk = 1;
          end
        end else if (b == 8'h00 || b == 8'hFF) begin
          nserr = 1; m_ext = 0; m_brk = 0;
        end else begin
          push = 1;
          ev   = '{ext: m_ext, brk: m_brk, code: b};
          m_ext = 0; m_brk = 0;
        end
      end
      drop = push && (exp_q.size() == DEPTH) && !pop;
      if (pop) void'(exp_q.pop_front());
      if (push && !drop) exp_q.push_back(ev);
      if (drop) m_ovf = 1;
      else if (bus.clr_ovf) m_ovf = 0;
      m_serr = nserr;
    end
  end

  task automatic drive(input bit v, input logic [7:0] c, input bit rdy, input bit clr);
    @(negedge fclk);
    bus.scan_valid = v;
    bus.scan_code  = c;
    bus.evt_ready  = rdy;
    bus.clr_ovf    = clr;
  endtask

  task automatic key(input logic [7:0] c, input bit rdy);
    drive(1'b1, c, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) drive(1'b0, 8'h00, rdy, 1'b0);
  endtask

  initial begin
    int rdy_pct;
    int r;
    logic [7:0] rc;
    rst_n          = 1'b0;
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    bus.evt_ready  = 1'b0;
    bus.clr_ovf    = 1'b0;
    #1;
    chk("reset_valid", bus.evt_valid, 0);
    chk("reset_level", bus.level, 0);
    chk("reset_ovf", bus.overflow, 0);
    repeat (3) @(negedge fclk);
    rst_n = 1'b1;

    // Make and break, plain and extended
    key(8'h1C, 1); key(8'hF0, 1); key(8'h1C, 1); idle(3, 1);
    key(8'hE0, 1); key(8'h75, 1); key(8'hE0, 1); key(8'hF0, 1); key(8'h75, 1); idle(3, 1);

    // Fill past capacity, then drain
    for (int i = 1; i <= 9; i++) key(8'(i), 0);
    idle(1, 0);
    #3;
    chk("full_level", bus.level, DEPTH);
    chk("full_ovf", bus.overflow, 1);
    idle(8, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2, 0);

    // Simultaneous push and pop while full
    for (int i = 1; i <= 8; i++) key(8'(8'h10 + i), 0);
    key(8'h2A, 1);
    idle(1, 0);
    #3;
    chk("fullpp_level", bus.level, DEPTH);
    chk("fullpp_ovf", bus.overflow, 0);
    idle(10, 1);

    // Protocol errors
    key(8'hF0, 1); key(8'hF0, 1); key(8'hFF, 1); key(8'h1C, 1); idle(3, 1);

    // Reset in the middle of a prefix with events queued
    key(8'h33, 0); key(8'hE0, 0); key(8'hF0, 0); idle(1, 0);
    @(negedge fclk);
    bus.scan_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_valid", bus.evt_valid, 0);
    chk("async_level", bus.level, 0);
    @(negedge fclk);
    rst_n          = 1'b1;
    bus.scan_valid = 1'b1;
    bus.scan_code  = 8'h75;
    bus.evt_ready  = 1'b0;
    idle(1, 0);
    #3;
    chk("post_rst_level", bus.level, 1);
    chk("post_rst_code", bus.evt_code, 8'h75);
    idle(2, 1);

    // Randomized traffic with varying consumer throughput
    for (int seg = 0; seg < 12; seg++) begin
      rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      for (int n = 0; n < 200; n++) begin
        r = $urandom_range(0, 9);
        if (r < 2)       rc = 8'hE0;
        else if (r < 4)  rc = 8'hF0;
        else if (r == 4) rc = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        else             rc = 8'($urandom_range(0, 255));
        drive($urandom_range(0, 99) < 70, rc, $urandom_range(0, 99) < rdy_pct,
              $urandom_range(0, 99) < 5);
      end
    end
    idle(20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
